// File: rtl/fetch_unit_if.sv
// Fetch stage bus: control inputs, byte-wide memory read port and instruction handoff.
// master = fetch_unit side, slave = memory/control side.
interface fetch_unit_if;
  logic        fetch_en;
  logic        pc_load;
  logic [15:0] pc_load_val;
  logic [15:0] mem_addr;
  logic        mem_cs;
  logic        mem_oe;
  logic [7:0]  mem_data;
  logic        insn_valid;
  logic        insn_ready;
  logic [7:0]  insn_opcode;
  logic        insn_cb;
  logic [15:0] insn_imm;
  logic [1:0]  insn_len;
  logic [15:0] insn_pc;

  modport master (
    input  fetch_en, pc_load, pc_load_val, mem_data, insn_ready,
    output mem_addr, mem_cs, mem_oe, insn_valid, insn_opcode, insn_cb,
           insn_imm, insn_len, insn_pc
  );

  modport slave (
    output fetch_en, pc_load, pc_load_val, mem_data, insn_ready,
    input  mem_addr, mem_cs, mem_oe, insn_valid, insn_opcode, insn_cb,
           insn_imm, insn_len, insn_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: reads prefix/opcode/operand bytes, MEM_LAT cycles each, and presents one
// decoded-length instruction at a time; pc_load redirects at any point.
module fetch_unit #(
  parameter logic [15:0] RESET_VEC = 16'h0000,
  parameter int          MEM_LAT   = 2
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  typedef enum logic [2:0] {IDLE, RD_OP, RD_CB, RD_LO, RD_HI, PRESENT} state_t;

  localparam int            CW   = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);

  state_t        state;
  logic [15:0]   pc;
  logic [15:0]   mem_addr;
  logic          mem_cs;
  logic          mem_oe;
  logic [CW-1:0] lat_cnt;
  logic          insn_valid;
  logic [7:0]    insn_opcode;
  logic          insn_cb;
  logic [15:0]   insn_imm;
  logic [1:0]    insn_len;
  logic [15:0]   insn_pc;

  logic          byte_done;
  logic          last_byte;
  logic          launch;
  logic [15:0]   launch_addr;
  logic [15:0]   next_pc;
  logic [15:0]   addr_inc;
  logic [1:0]    op_bytes;

  function automatic logic [1:0] op_len(input logic [7:0] op);
    case (op)
      8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
      8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
      8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
      8'hE0, 8'hF0, 8'hE8, 8'hF8:                       op_len = 2'd2;
      8'h01, 8'h11, 8'h21, 8'h31, 8'h08,
      8'hC2, 8'hC3, 8'hCA, 8'hD2, 8'hDA,
      8'hC4, 8'hCC, 8'hCD, 8'hD4, 8'hDC, 8'hEA, 8'hFA: op_len = 2'd3;
      default:                                          op_len = 2'd1;
    endcase
  endfunction

  assign byte_done = mem_cs && (lat_cnt == LAST);
  assign next_pc   = insn_pc + {14'd0, insn_len};
  assign addr_inc  = mem_addr + 16'd1;
  assign op_bytes  = op_len(bus.mem_data);

  // A new read burst starts from IDLE, after a redirect (RD_OP entered with cs low),
  // or straight out of PRESENT on accept.
  always_comb begin
    launch      = 1'b0;
    launch_addr = pc;
    last_byte   = 1'b0;
    case (state)
      IDLE:    launch = bus.fetch_en;
      RD_OP: begin
        launch    = !mem_cs;
        last_byte = byte_done && (bus.mem_data != 8'hCB) && (op_bytes == 2'd1);
      end
      RD_CB:   last_byte = byte_done;
      RD_LO:   last_byte = byte_done && (insn_len != 2'd3);
      RD_HI:   last_byte = byte_done;
      PRESENT: begin
        launch      = bus.insn_ready && bus.fetch_en;
        launch_addr = next_pc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_VEC;
      mem_addr    <= 16'h0000;
      mem_cs      <= 1'b0;
      mem_oe      <= 1'b0;
      lat_cnt     <= '0;
      insn_valid  <= 1'b0;
      insn_opcode <= 8'h00;
      insn_cb     <= 1'b0;
      insn_imm    <= 16'h0000;
      insn_len    <= 2'd0;
      insn_pc     <= 16'h0000;
    end else if (bus.pc_load) begin
      pc         <= bus.pc_load_val;
      mem_addr   <= bus.pc_load_val;
      mem_cs     <= 1'b0;
      mem_oe     <= 1'b0;
      lat_cnt    <= '0;
      insn_valid <= 1'b0;
      state      <= bus.fetch_en ? RD_OP : IDLE;
    end else begin
      if (mem_cs && !byte_done)
        lat_cnt <= lat_cnt + 1'b1;
      if (byte_done) begin
        lat_cnt  <= '0;
        mem_addr <= addr_inc;
      end

      case (state)
        RD_OP: begin
          if (byte_done) begin
            if (bus.mem_data == 8'hCB) begin
              insn_cb <= 1'b1;
              state   <= RD_CB;
            end else begin
              insn_opcode <= bus.mem_data;
              insn_len    <= op_bytes;
              if (op_bytes != 2'd1)
                state <= RD_LO;
            end
          end
        end
        RD_CB: begin
          if (byte_done) begin
            insn_opcode <= bus.mem_data;
            insn_len    <= 2'd2;
          end
        end
        RD_LO: begin
          if (byte_done) begin
            insn_imm[7:0] <= bus.mem_data;
            if (insn_len == 2'd3)
              state <= RD_HI;
          end
        end
        RD_HI: begin
          if (byte_done)
            insn_imm[15:8] <= bus.mem_data;
        end
        PRESENT: begin
          if (bus.insn_ready) begin
            insn_valid <= 1'b0;
            pc         <= next_pc;
            state      <= IDLE;
          end
        end
        default: ;
      endcase

      if (last_byte) begin
        mem_cs     <= 1'b0;
        mem_oe     <= 1'b0;
        insn_valid <= 1'b1;
        state      <= PRESENT;
      end

      if (launch) begin
        state       <= RD_OP;
        mem_addr    <= launch_addr;
        mem_cs      <= 1'b1;
        mem_oe      <= 1'b1;
        lat_cnt     <= '0;
        insn_pc     <= launch_addr;
        insn_opcode <= 8'h00;
        insn_cb     <= 1'b0;
        insn_imm    <= 16'h0000;
        insn_len    <= 2'd0;
      end
    end
  end

  assign bus.mem_addr    = mem_addr;
  assign bus.mem_cs      = mem_cs;
  assign bus.mem_oe      = mem_oe;
  assign bus.insn_valid  = insn_valid;
  assign bus.insn_opcode = insn_opcode;
  assign bus.insn_cb     = insn_cb;
  assign bus.insn_imm    = insn_imm;
  assign bus.insn_len    = insn_len;
  assign bus.insn_pc     = insn_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written redirect/stall/reset sequences,
// then random memory and handshake traffic against a byte-level instruction model.
module tb_fetch_unit;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit #(.RESET_VEC(16'h0000), .MEM_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem [0:65535];

  // Memory returns garbage until the address has been held for LAT cycles.
  logic        prev_cs;
  logic [15:0] prev_addr;
  int          prev_age;
  int          age_now;
  always_comb age_now = (bus.mem_cs && prev_cs && bus.mem_addr == prev_addr) ? prev_age + 1 : 0;
  always @(posedge clk) begin
    prev_cs   <= bus.mem_cs;
    prev_addr <= bus.mem_addr;
    prev_age  <= age_now;
  end
  assign bus.mem_data = (bus.mem_cs && bus.mem_oe && age_now >= LAT - 1) ?
                        mem[bus.mem_addr] : ~mem[bus.mem_addr];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pack(input logic [7:0] op, input logic cb,
                                       input logic [15:0] imm, input logic [1:0] len,
                                       input logic [15:0] pc);
    return {21'd0, op, cb, imm, len, pc};
  endfunction

  function automatic logic [63:0] fields();
    return pack(bus.insn_opcode, bus.insn_cb, bus.insn_imm, bus.insn_len, bus.insn_pc);
  endfunction

  // Reference model: instruction length by membership in the opcode lists.
  logic [7:0] two_ops [26] = '{8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
                               8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38, 8'hC6, 8'hCE,
                               8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE, 8'hE0, 8'hF0,
                               8'hE8, 8'hF8};
  logic [7:0] three_ops [17] = '{8'h01, 8'h11, 8'h21, 8'h31, 8'h08, 8'hC2, 8'hC3, 8'hCA,
                                 8'hD2, 8'hDA, 8'hC4, 8'hCC, 8'hCD, 8'hD4, 8'hDC, 8'hEA,
                                 8'hFA};

  function automatic int ref_len(input logic [7:0] op);
    foreach (two_ops[i])   if (two_ops[i] == op)   return 2;
    foreach (three_ops[i]) if (three_ops[i] == op) return 3;
    return 1;
  endfunction

  function automatic logic [63:0] predict(input logic [15:0] p);
    logic [15:0] p1, p2;
    logic [7:0]  b0;
    int          n;
    p1 = p + 16'd1;
    p2 = p + 16'd2;
    b0 = mem[p];
    if (b0 == 8'hCB) return pack(mem[p1], 1'b1, 16'h0000, 2'd2, p);
    n = ref_len(b0);
    if (n == 1) return pack(b0, 1'b0, 16'h0000, 2'd1, p);
    if (n == 2) return pack(b0, 1'b0, {8'h00, mem[p1]}, 2'd2, p);
    return pack(b0, 1'b0, {mem[p2], mem[p1]}, 2'd3, p);
  endfunction

  // Waits (from a negedge) until insn_valid, counting cycles with a read in flight.
  task automatic wait_valid(output int reads, output logic ok);
    reads = 0;
    ok    = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.insn_valid) begin
        ok = 1'b1;
        break;
      end
      if (bus.mem_cs) reads++;
      @(negedge clk);
    end
  endtask

  task automatic redirect(input logic [15:0] target);
    bus.pc_load     = 1'b1;
    bus.pc_load_val = target;
    @(negedge clk);
    bus.pc_load     = 1'b0;
  endtask

  typedef struct {
    logic [15:0] pc;
    logic [7:0]  b0, b1, b2;
    logic [7:0]  op;
    logic        cb;
    logic [15:0] imm;
    logic [1:0]  len;
    logic [15:0] nxt;
  } vec_t;

  vec_t vt [10];

  task automatic run_vec(input vec_t v);
    logic [15:0] a1, a2;
    int          reads;
    logic        ok;
    a1 = v.pc + 16'd1;
    a2 = v.pc + 16'd2;
    mem[v.pc] = v.b0;
    mem[a1]   = v.b1;
    mem[a2]   = v.b2;
    redirect(v.pc);
    wait_valid(reads, ok);
    check("vec_valid_timeout", {63'd0, ok}, 64'd1);
    check("vec_fields", fields(), pack(v.op, v.cb, v.imm, v.len, v.pc));
    check("vec_read_cycles", reads, v.len * LAT);
    bus.insn_ready = 1'b1;
    @(negedge clk);
    bus.insn_ready = 1'b0;
    check("vec_next_read", {bus.mem_cs, bus.mem_addr}, {1'b1, v.nxt});
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int          reads;
    logic        ok;
    logic [15:0] exp_pc;
    logic [63:0] pk;
    int          accepted;
    logic        r, pl;
    logic [15:0] val;

    vt[0] = '{16'h0100, 8'hC3, 8'h50, 8'h01, 8'hC3, 1'b0, 16'h0150, 2'd3, 16'h0103};
    vt[1] = '{16'h0200, 8'hCB, 8'h37, 8'h00, 8'h37, 1'b1, 16'h0000, 2'd2, 16'h0202};
    vt[2] = '{16'hFFFF, 8'h3E, 8'h12, 8'h00, 8'h3E, 1'b0, 16'h0012, 2'd2, 16'h0001};
    vt[3] = '{16'h1234, 8'h06, 8'hAB, 8'h00, 8'h06, 1'b0, 16'h00AB, 2'd2, 16'h1236};
    vt[4] = '{16'h2000, 8'hCD, 8'h34, 8'h12, 8'hCD, 1'b0, 16'h1234, 2'd3, 16'h2003};
    vt[5] = '{16'h3000, 8'h76, 8'h11, 8'h22, 8'h76, 1'b0, 16'h0000, 2'd1, 16'h3001};
    vt[6] = '{16'hFFFE, 8'h01, 8'hEF, 8'hBE, 8'h01, 1'b0, 16'hBEEF, 2'd3, 16'h0001};
    vt[7] = '{16'h4000, 8'hCB, 8'h7C, 8'h00, 8'h7C, 1'b1, 16'h0000, 2'd2, 16'h4002};
    vt[8] = '{16'h5000, 8'hE0, 8'h80, 8'h00, 8'hE0, 1'b0, 16'h0080, 2'd2, 16'h5002};
    vt[9] = '{16'h6000, 8'hFA, 8'h00, 8'hC0, 8'hFA, 1'b0, 16'hC000, 2'd3, 16'h6003};

    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

    rst             = 1'b1;
    bus.fetch_en    = 1'b1;
    bus.pc_load     = 1'b0;
    bus.pc_load_val = 16'h0000;
    bus.insn_ready  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", {bus.mem_addr, bus.mem_cs, bus.mem_oe, bus.insn_valid, fields()},
          {16'h0000, 3'b000, pack(8'h00, 1'b0, 16'h0000, 2'd0, 16'h0000)});

    // Cycle 0 below is the first cycle with a read in flight after reset.
    rst = 1'b0;
    @(negedge clk);
    check("first_read_c0", {bus.mem_cs, bus.mem_oe, bus.mem_addr}, {2'b11, 16'h0000});
    @(negedge clk);
    check("first_read_c1", {bus.mem_cs, bus.insn_valid, bus.mem_addr}, {2'b10, 16'h0000});
    @(negedge clk);
    check("first_valid_c2", {bus.insn_valid, bus.mem_cs, fields()},
          {2'b10, pack(8'h00, 1'b0, 16'h0000, 2'd1, 16'h0000)});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_hold", {bus.insn_valid, bus.mem_cs, fields()},
            {2'b10, pack(8'h00, 1'b0, 16'h0000, 2'd1, 16'h0000)});
    end
    bus.insn_ready = 1'b1;
    @(negedge clk);
    bus.insn_ready = 1'b0;
    check("read_after_accept", {bus.mem_cs, bus.insn_valid, bus.mem_addr}, {2'b10, 16'h0001});

    for (int i = 0; i < 10; i++) run_vec(vt[i]);

    // Redirect while the low operand byte is being read.
    mem[16'h7000] = 8'hC3;
    mem[16'h7001] = 8'h00;
    mem[16'h7002] = 8'h80;
    mem[16'h0040] = 8'h00;
    redirect(16'h7000);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.mem_cs && bus.mem_addr == 16'h7001) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("reach_rd_lo", {63'd0, ok}, 64'd1);
    redirect(16'h0040);
    check("redirect_abandon", {bus.insn_valid, bus.mem_cs, bus.mem_addr}, {2'b00, 16'h0040});
    wait_valid(reads, ok);
    check("redirect_valid_timeout", {63'd0, ok}, 64'd1);
    check("redirect_fields", fields(), pack(8'h00, 1'b0, 16'h0000, 2'd1, 16'h0040));

    // Accept and redirect in the same cycle: the redirect target wins.
    bus.insn_ready  = 1'b1;
    bus.pc_load     = 1'b1;
    bus.pc_load_val = 16'h0100;
    @(negedge clk);
    bus.insn_ready  = 1'b0;
    bus.pc_load     = 1'b0;
    check("accept_with_load", {bus.insn_valid, bus.mem_addr}, {1'b0, 16'h0100});
    wait_valid(reads, ok);
    check("accept_load_timeout", {63'd0, ok}, 64'd1);
    check("accept_load_fields", fields(), pack(8'hC3, 1'b0, 16'h0150, 2'd3, 16'h0100));

    // fetch_en dropped mid-instruction: completes, then idles.
    redirect(16'h2000);
    @(negedge clk);
    bus.fetch_en = 1'b0;
    wait_valid(reads, ok);
    check("fetch_en_off_timeout", {63'd0, ok}, 64'd1);
    check("fetch_en_off_fields", fields(), pack(8'hCD, 1'b0, 16'h1234, 2'd3, 16'h2000));
    bus.insn_ready = 1'b1;
    @(negedge clk);
    bus.insn_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("idle_no_fetch", {bus.insn_valid, bus.mem_cs}, 2'b00);
      @(negedge clk);
    end
    bus.fetch_en = 1'b1;
    @(negedge clk);
    check("resume_fetch", {bus.mem_cs, bus.mem_addr}, {1'b1, 16'h2003});

    // Reset in the middle of a read.
    rst = 1'b1;
    @(negedge clk);
    check("reset_mid_read", {bus.mem_addr, bus.mem_cs, bus.mem_oe, bus.insn_valid, fields()},
          {16'h0000, 3'b000, pack(8'h00, 1'b0, 16'h0000, 2'd0, 16'h0000)});

    // Random memory, ready and redirects against the model.
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    rst      = 1'b0;
    exp_pc   = 16'h0000;
    accepted = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      r   = ($urandom_range(0, 3) != 0);
      pl  = ($urandom_range(0, 19) == 0);
      val = 16'($urandom);
      if (bus.insn_valid) begin
        pk = predict(exp_pc);
        check("rand_insn", fields(), pk);
        if (r) begin
          exp_pc = exp_pc + {14'd0, pk[17:16]};
          accepted++;
        end
      end
      if (pl) exp_pc = val;
      bus.insn_ready  = r;
      bus.pc_load     = pl;
      bus.pc_load_val = val;
    end
    bus.insn_ready = 1'b0;
    bus.pc_load    = 1'b0;
    check("rand_progress", {63'd0, accepted >= 100}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
